// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: FSM state codes and the
// fill bit used for the divide-by-zero quotient.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } div_state_e;

  // Every quotient bit takes this value when the divisor is zero.
  localparam logic DZ_Q_FILL = 1'b1;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract the
// divisor from the partial remainder and keep the result if it did not borrow.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor always holds, so the top bit of trial is a reliable sign.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned integer divider with divide-by-zero fast path,
// flush, and a stall/one-cycle-result contract toward the pipeline.
module iter_divider
  import div_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             en,
  input  logic             div_sign,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             res_ready,
  output logic             div_by_zero,
  output logic             stall_all,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  // Handshake: while stall_all=1 the pipeline holds; the result is valid only
  // in the single cycle res_ready=1 and must be captured by the consumer then.

  div_state_e state, state_nxt;

  logic [WIDTH-1:0] rem, quo, divisor, raw_a;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [CNT_W-1:0] cnt;
  logic             mode, sign_q, sign_r, dz;
  logic             accept;

  assign accept = (state == IDLE) && en && !flush;

  always_comb begin
    mag_a = (div_sign && src_a[WIDTH-1]) ? -src_a : src_a;
    mag_b = (div_sign && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (src_b == '0) ? DONE : CALC;
      CALC: begin
        if (flush)                        state_nxt = IDLE;
        else if (cnt == CNT_W'(1))        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode    <= 1'b0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dz      <= 1'b0;
      raw_a   <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
    end else if (accept) begin
      mode    <= div_sign;
      sign_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
      sign_r  <= src_a[WIDTH-1];
      dz      <= (src_b == '0);
      raw_a   <= src_a;
      divisor <= mag_b;
      quo     <= mag_a;
      rem     <= '0;
      cnt     <= CNT_W'(WIDTH);
    end else if (state == CALC) begin
      rem <= rem_step;
      quo <= quo_step;
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Result is driven only in the DONE cycle; zeros otherwise.
  always_comb begin
    res_ready   = 1'b0;
    div_by_zero = 1'b0;
    stall_all   = 1'b0;
    q           = '0;
    r           = '0;
    busy        = (state == CALC) || (state == DONE);
    fsm_state   = state;
    case (state)
      IDLE: stall_all = en && !flush;
      CALC: stall_all = !flush;
      DONE: begin
        res_ready = !flush;
        if (!flush) begin
          if (dz) begin
            q           = {WIDTH{DZ_Q_FILL}};
            r           = raw_a;
            div_by_zero = 1'b1;
          end else begin
            q = (mode && sign_q) ? -quo : quo;
            r = (mode && sign_r) ? -rem : rem;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: a 32-bit and an 8-bit instance driven by a
// linear sequence of steps with hand-computed quotient/remainder/latency.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_a, src_b;
  logic        en, div_sign, flush;
  logic [31:0] q, r;
  logic        res_ready, div_by_zero, stall_all, busy;
  logic [1:0]  fsm_state;

  logic [7:0]  a8, b8;
  logic        en8, sign8, flush8;
  logic [7:0]  q8, r8;
  logic        rdy8, dz8, stall8, busy8;
  logic [1:0]  st8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iter_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .en(en),
    .div_sign(div_sign), .flush(flush), .q(q), .r(r), .res_ready(res_ready),
    .div_by_zero(div_by_zero), .stall_all(stall_all), .busy(busy),
    .fsm_state(fsm_state)
  );

  iter_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .src_a(a8), .src_b(b8), .en(en8),
    .div_sign(sign8), .flush(flush8), .q(q8), .r(r8), .res_ready(rdy8),
    .div_by_zero(dz8), .stall_all(stall8), .busy(busy8), .fsm_state(st8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; en is raised in cycle 0.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int lat, input bit poke, input string tag);
    int  cyc;
    bit  seen;
    bit  stall_ok;
    src_a = a; src_b = b; div_sign = sgn; en = 1'b1;
    #1 check({tag, ".stall0"}, 32'(stall_all), 32'd1);
    cyc = 0; seen = 0; stall_ok = 1;
    while (!seen && cyc < lat + 5) begin
      @(negedge clk);
      cyc++;
      en    = 1'b0;
      src_a = $urandom;
      src_b = $urandom;
      div_sign = ~sgn;
      if (poke && cyc == 5) begin
        en = 1'b1; src_a = 32'd9; src_b = 32'd3;
      end
      #1;
      if (res_ready) seen = 1;
      else if (stall_all !== 1'b1) stall_ok = 0;
    end
    en = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'(lat));
    check({tag, ".stall_calc"}, 32'(stall_ok), 32'd1);
    check({tag, ".q"}, q, eq);
    check({tag, ".r"}, r, er);
    check({tag, ".dz"}, 32'(div_by_zero), 32'(edz));
    check({tag, ".stall_done"}, 32'(stall_all), 32'd0);
    check({tag, ".busy_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check({tag, ".rdy_after"}, 32'(res_ready), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".q_after"}, q, 32'd0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                      input logic [7:0] eq, input logic [7:0] er, input int lat,
                      input string tag);
    int cyc;
    bit seen;
    a8 = a; b8 = b; sign8 = sgn; en8 = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < lat + 5) begin
      @(negedge clk);
      cyc++;
      en8 = 1'b0;
      #1;
      if (rdy8) seen = 1;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(lat));
    check({tag, ".q"}, 32'(q8), 32'(eq));
    check({tag, ".r"}, 32'(r8), 32'(er));
    check({tag, ".dz"}, 32'(dz8), 32'd0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst = 1'b1; en = 0; flush = 0; div_sign = 0; src_a = 0; src_b = 0;
    en8 = 0; flush8 = 0; sign8 = 0; a8 = 0; b8 = 0;
    #3;
    check("reset.q", q, 32'd0);
    check("reset.r", r, 32'd0);
    check("reset.flags", {28'd0, res_ready, div_by_zero, stall_all, busy}, 32'd0);
    check("reset.state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b0, "u100_7");
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, 1'b0, "s_m7_2");
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 33, 1'b0, "s7_m2");
    run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0, 33, 1'b0, "s_m100_m7");
    run_div(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, 33, 1'b0, "u_big_2");
    run_div(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 1'b0, "dz_u");
    run_div(32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 1'b0, "dz_s");
    run_div(32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1, 1'b0, "dz_neg");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 33, 1'b0, "s_ovf");
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 33, 1'b0, "u_max_1");
    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b1, "en_busy_ignored");

    // flush in IDLE cancels a simultaneous en
    src_a = 32'd10; src_b = 32'd2; en = 1'b1; flush = 1'b1; div_sign = 0;
    #1 check("idle_flush.stall", 32'(stall_all), 32'd0);
    @(negedge clk);
    en = 0; flush = 0;
    #1 check("idle_flush.busy", 32'(busy), 32'd0);

    // flush mid-CALC at cycle 10, new op accepted at cycle 11
    src_a = 32'd1000; src_b = 32'd3; en = 1'b1;
    seen = 0;
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      en = 0;
      if (cyc == 10) flush = 1'b1;
      #1;
      if (res_ready) seen = 1;
    end
    check("flush.stall", 32'(stall_all), 32'd0);
    check("flush.rdy_pre", 32'(seen), 32'd0);
    @(negedge clk);
    flush = 0;
    #1;
    check("flush.state", 32'(fsm_state), 32'd0);
    check("flush.busy", 32'(busy), 32'd0);
    run_div(32'd30, 32'd4, 1'b0, 32'd7, 32'd2, 1'b0, 33, 1'b0, "after_flush");

    run8(8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 9, "w8_255_16");
    run8(8'h80, 8'd3, 1'b1, 8'hD6, 8'hFE, 9, "w8_m128_3");

    // asynchronous reset in the middle of a calculation
    @(negedge clk);
    src_a = 32'd1000; src_b = 32'd3; div_sign = 0; en = 1'b1;
    repeat (10) begin
      @(negedge clk);
      en = 0;
    end
    #2 rst = 1'b1;
    #1;
    check("arst.q", q, 32'd0);
    check("arst.r", r, 32'd0);
    check("arst.flags", {28'd0, res_ready, div_by_zero, stall_all, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (res_ready) seen = 1;
    end
    check("arst.no_result", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised multi-cycle integer divider for the execute unit. It replaces the vendor-IP divider wrapper with an in-house radix-2 restoring core.
- Supports signed and unsigned division at any WIDTH.
- Adds a defined divide-by-zero fast path, a pipeline flush/cancel input and a busy indication.
- Drives the same stall/ready contract toward the pipeline: stall_all holds the pipeline until the one-cycle res_ready pulse.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits; legal range >= 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- src_a  in  WIDTH  dividend; sampled only on the accepting cycle.
- src_b  in  WIDTH  divisor; sampled only on the accepting cycle.
- en  in  1  start request; honoured only in IDLE.
- div_sign  in  1  1 = signed (two's complement), 0 = unsigned; sampled with en.
- flush  in  1  cancel any in-flight operation; has priority over en.
- q  out  WIDTH  quotient; valid only while res_ready=1, otherwise 0.
- r  out  WIDTH  remainder; valid only while res_ready=1, otherwise 0.
- res_ready  out  1  one-cycle pulse, result valid.
- div_by_zero  out  1  qualifies res_ready; 1 when the divisor was 0.
- stall_all  out  1  pipeline stall request (combinational).
- busy  out  1  1 in CALC or DONE.

Behaviour:
- Reset: asynchronous and active-high. All registers clear and state = IDLE. Outputs q=0, r=0, res_ready=0, div_by_zero=0, stall_all=0, busy=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - stall_all = en & ~flush.
  - On en & ~flush: latch div_sign, sign_q = sign(a)^sign(b), sign_r = sign(a), |a|, |b| and the raw src_a.
  - Magnitudes are taken only in signed mode; unsigned mode uses the operands as-is.
  - If src_b==0: set dz=1 and go to DONE.
  - Otherwise load the counter with WIDTH and go to CALC.
- CALC:
  - One restoring step per cycle: shift {rem,quo} left by 1; trial = rem - |b| at WIDTH+1 bits; if non-negative, rem=trial and quo[0]=1.
  - Counter decrements each step. When it reaches 1 and that step completes, go to DONE.
  - stall_all = 1.
- DONE:
  - res_ready = 1 and stall_all = 0 for exactly one cycle, then IDLE.
  - q = sign_q ? -quo : quo; r = sign_r ? -rem : rem (sign correction only in signed mode).
  - If dz: q = all ones, r = raw src_a, div_by_zero = 1.
- Latency:
  - en accepted at cycle 0 gives res_ready at cycle WIDTH+1 (33 for WIDTH=32).
  - Divide-by-zero gives res_ready at cycle 1.
- Signed overflow: MIN / -1 yields q = MIN, r = 0 with no exception flag; this falls out naturally from the magnitude path.
- flush:
  - In CALC or DONE: next state = IDLE, res_ready suppressed in that cycle, stall_all=0.
  - In IDLE: any en in the same cycle is ignored.
- en outside IDLE is ignored; operands are not re-sampled.
- Back-to-back operation: en may be asserted in the cycle immediately after DONE (state IDLE).
- Reset asserted mid-operation aborts immediately; no res_ready is produced.
- There are no holding registers for q/r beyond DONE. The consumer must capture on res_ready.

Decomposition:
- Package div_pkg: state encodings (IDLE/CALC/DONE as 2-bit localparams) and the divide-by-zero result constant pattern (all ones).
- Sub-module div_iter_step: purely combinational single restoring step, parametrised by WIDTH. Inputs rem, quo, divisor. Outputs next rem and next quo.
- The top-level module holds the FSM, counter, operand latch and sign fix-up.

Test Plan:
- Unsigned, WIDTH=32: 100/7, en at cycle 0 -> res_ready at cycle 33, q=14, r=2, div_by_zero=0; stall_all high cycles 0-32, low at 33.
- Signed: 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also 7 / -2 -> q=0xFFFFFFFD, r=1.
- Divide by zero: 5/0, in both signed and unsigned mode -> res_ready at cycle 1, q=0xFFFFFFFF, r=5, div_by_zero=1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- Flush at cycle 10 of a divide -> state IDLE at cycle 11, no res_ready ever. A new en at cycle 11 (30/4) -> q=7, r=2 at cycle 44.
- WIDTH=8 instance, unsigned 255/16 -> res_ready at cycle 9, q=15, r=15.
- Async rst pulse mid-CALC -> all outputs 0 immediately.
